// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, and buffers
// responses in a 2-entry FIFO whose head drives the decode interface.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_instr,
  input  logic        imem_resp_err,
  output logic        fetch_o_valid,
  output logic [63:0] fetch_o_pc,
  output logic [31:0] fetch_o_instr,
  output logic        fetch_o_err,
  input  logic        decode_ready
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
  } entry_t;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  entry_t      ent0_q, ent0_d;
  entry_t      ent1_q, ent1_d;

  logic   accept;
  logic   pop;
  logic   push;
  entry_t new_entry;

  assign imem_req_valid = !rst && (state_q == S_REQ) && (count_q < DEPTH);
  assign imem_req_addr  = pc_q;
  assign fetch_o_valid  = (count_q != 2'd0);
  assign fetch_o_pc     = ent0_q.pc;
  assign fetch_o_instr  = ent0_q.instr;
  assign fetch_o_err    = ent0_q.err;

  assign accept    = imem_req_valid && imem_req_ready;
  assign pop       = fetch_o_valid && decode_ready;
  // A redirect kills a response arriving in the same cycle, so it never reaches the FIFO.
  assign push      = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
  assign new_entry = '{pc: req_pc_q, instr: imem_resp_instr, err: imem_resp_err};

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;

    unique case (state_q)
      S_REQ:  if (accept) begin
                state_d  = S_WAIT;
                pc_d     = pc_q + 64'd4;
                req_pc_d = pc_q;
              end
      S_WAIT: if (imem_resp_valid) state_d = imem_resp_err ? S_HALT : S_REQ;
      S_DROP: if (imem_resp_valid) state_d = S_REQ;
      S_HALT: ;
    endcase

    // Shift FIFO: ent0 is always the head, so the outputs come straight from a register.
    if (push && !pop) begin
      if (count_q == 2'd0) ent0_d = new_entry;
      else                 ent1_d = new_entry;
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      ent0_d  = ent1_q;
      count_d = count_q - 2'd1;
    end else if (push && pop) begin
      if (count_q == 2'd1) begin
        ent0_d = new_entry;
      end else begin
        ent0_d = ent1_q;
        ent1_d = new_entry;
      end
    end

    // Redirect overrides everything; an outstanding request must still drain through DROP.
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = redirect_pc & ~64'h3;
      unique case (state_q)
        S_REQ:  state_d = accept ? S_DROP : S_REQ;
        S_WAIT: state_d = imem_resp_valid ? S_REQ : S_DROP;
        S_DROP: state_d = imem_resp_valid ? S_REQ : S_DROP;
        S_HALT: state_d = S_REQ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      count_q  <= 2'd0;
      // NOTE: FIFO data registers are reset because the head drives fetch_o, which must read 0 after reset.
      ent0_q   <= '0;
      ent1_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
    end
  end

`ifndef SYNTHESIS
  // Request gating guarantees there is always room for the single outstanding response.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && count_q == DEPTH));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: the bench plays imem and decode, predicts the fetch stream
// with a transaction-level model, and a separate monitor compares each consumed entry.
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_instr = '0;
  logic        imem_resp_err = 1'b0;
  logic        fetch_o_valid;
  logic [63:0] fetch_o_pc;
  logic [31:0] fetch_o_instr;
  logic        fetch_o_err;
  logic        decode_ready = 1'b0;

  ifu_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_instr(imem_resp_instr), .imem_resp_err(imem_resp_err),
    .fetch_o_valid(fetch_o_valid), .fetch_o_pc(fetch_o_pc), .fetch_o_instr(fetch_o_instr),
    .fetch_o_err(fetch_o_err), .decode_ready(decode_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the fetch stream must look like at transaction level.
  bit          outst   = 1'b0;
  bit          dropped = 1'b0;
  bit          halted  = 1'b0;
  logic [63:0] exp_pc  = RESET_PC;
  logic [63:0] acc_addr = '0;
  int          wait_cnt = 0;
  int          delay    = 1;

  // Stimulus knobs.
  bit          k_rst = 1'b1;
  bit          k_redir = 1'b0;
  bit          k_redir_on_resp = 1'b0;
  logic [63:0] k_target = '0;
  logic [63:0] k_err_addr = '1;
  int k_req_p = 100, k_dec_p = 100, k_dmin = 1, k_dmax = 1;
  int k_err_p = 0, k_redir_p = 0, k_rst_p = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check at +1, model the coming posedge at +3.
  task automatic do_cycle();
    bit          do_resp;
    bit          acc;
    bit          forced;
    logic [63:0] tgt;
    @(negedge clk);
    rst = k_rst || ($urandom_range(999) < k_rst_p);
    do_resp = 1'b0;
    if (outst && !rst) begin
      wait_cnt++;
      if (wait_cnt >= delay) do_resp = 1'b1;
    end
    imem_resp_valid = do_resp;
    imem_resp_instr = $urandom;
    imem_resp_err   = do_resp && ((acc_addr == k_err_addr) || ($urandom_range(999) < k_err_p));
    imem_req_ready  = ($urandom_range(99) < k_req_p);
    decode_ready    = ($urandom_range(99) < k_dec_p);
    forced = k_redir || (k_redir_on_resp && do_resp);
    redirect_valid = !rst && (forced || ($urandom_range(999) < k_redir_p));
    if (forced) tgt = k_target;
    else if ($urandom_range(3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
    else tgt = {32'h0, $urandom};
    redirect_pc = tgt;
    if (redirect_valid && forced) begin
      k_redir = 1'b0;
      k_redir_on_resp = 1'b0;
    end

    #1;
    check("req_valid", 64'(imem_req_valid), 64'(!rst && !outst && !halted && exp_q.size() < 2));
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
    check("out_valid", 64'(fetch_o_valid), 64'(exp_q.size() != 0));
    acc = imem_req_valid && imem_req_ready;

    #2;
    if (rst) begin
      outst = 1'b0; dropped = 1'b0; halted = 1'b0;
      exp_q.delete();
      exp_pc = RESET_PC;
    end else begin
      if (do_resp) begin
        outst = 1'b0;
        if (!redirect_valid && !dropped) begin
          exp_q.push_back('{pc: acc_addr, instr: imem_resp_instr, err: imem_resp_err});
          if (imem_resp_err) halted = 1'b1;
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        halted = 1'b0;
        exp_pc = redirect_pc & ~64'h3;
        if (outst) dropped = 1'b1;
      end
      if (acc) begin
        outst    = 1'b1;
        dropped  = redirect_valid;
        acc_addr = imem_req_addr;
        wait_cnt = 0;
        delay    = $urandom_range(k_dmax, k_dmin);
        if (!redirect_valid) exp_pc = exp_pc + 64'd4;
      end
    end
  endtask

  // Monitor: compares every entry decode actually consumes against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && !redirect_valid && fetch_o_valid && decode_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pc %h, expected no entry (t=%0t)", fetch_o_pc, $time);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", fetch_o_pc, e.pc);
        check("out_instr", 64'(fetch_o_instr), 64'(e.instr));
        check("out_err", 64'(fetch_o_err), 64'(e.err));
      end
    end
  end

  task automatic wait_new_accept();
    for (int i = 0; i < 30 && outst; i++) do_cycle();
    for (int i = 0; i < 30 && !outst; i++) do_cycle();
    if (!outst) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no request accept, expected one within 30 cycles");
    end
  endtask

  initial begin
    // Reset and its output values.
    repeat (3) do_cycle();
    check("rst_pc", fetch_o_pc, 64'h0);
    check("rst_instr", 64'(fetch_o_instr), 64'h0);
    check("rst_err", 64'(fetch_o_err), 64'h0);
    k_rst = 1'b0;

    // Zero-wait streaming from RESET_PC.
    repeat (12) do_cycle();

    // Decode back-pressure: FIFO fills to 2 and requests stop.
    k_dec_p = 0;
    repeat (10) do_cycle();
    check("bp_full_valid", 64'(fetch_o_valid), 64'h1);
    check("bp_no_req", 64'(imem_req_valid), 64'h0);
    k_dec_p = 100;
    repeat (6) do_cycle();

    // Redirect while a slow response is outstanding.
    k_dmin = 4; k_dmax = 4;
    wait_new_accept();
    k_target = 64'h0000_0000_8000_1002; k_redir = 1'b1;
    repeat (12) do_cycle();

    // Redirect in the same cycle as the response.
    k_dmin = 1; k_dmax = 1;
    k_target = 64'h0000_0000_8000_2000; k_redir_on_resp = 1'b1;
    repeat (10) do_cycle();

    // Access fault at 0x80000008 halts fetch until a redirect.
    k_rst = 1'b1; repeat (2) do_cycle(); k_rst = 1'b0;
    k_err_addr = 64'h0000_0000_8000_0008;
    repeat (15) do_cycle();
    k_err_addr = '1;
    k_target = 64'h0000_0000_8000_3000; k_redir = 1'b1;
    repeat (8) do_cycle();

    // PC wrap at the top of the address space.
    k_target = 64'hFFFF_FFFF_FFFF_FFFC; k_redir = 1'b1;
    repeat (10) do_cycle();

    // Reset while waiting on imem.
    k_dmin = 3; k_dmax = 3;
    wait_new_accept();
    k_rst = 1'b1; repeat (2) do_cycle(); k_rst = 1'b0;
    repeat (8) do_cycle();

    // Randomized traffic.
    k_req_p = 70; k_dec_p = 60; k_dmin = 1; k_dmax = 3;
    k_err_p = 30; k_redir_p = 40; k_rst_p = 2;
    repeat (4000) do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
